// File: rtl/pdm_pkg.sv
// Shared width helpers and mic/side to channel mapping for the PDM CIC receiver.
package pdm_pkg;

    localparam int SIDES      = 2;
    localparam int SIDE_LEFT  = 0;
    localparam int SIDE_RIGHT = 1;

    // Bit growth of an ORDER-stage CIC decimating by DECIM, plus the sign bit.
    function automatic int cic_width(input int order, input int decim);
        return order * $clog2(decim) + 1;
    endfunction

    function automatic int chan_idx_width(input int chans);
        return (chans > 2) ? $clog2(chans) : 1;
    endfunction

    function automatic int chan_of(input int mic, input int side);
        return SIDES * mic + side;
    endfunction

endpackage

// File: rtl/pdm_cic_chan.sv
// One PDM channel: ORDER cascaded integrators at the bit rate, ORDER combs at the
// decimated rate. All arithmetic wraps modulo 2^W by design.
module pdm_cic_chan
    import pdm_pkg::*;
#(
    parameter  int DECIM = 32,
    parameter  int ORDER = 3,
    localparam int W     = cic_width(ORDER, DECIM)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                strobe,
    input  logic                dec_strobe,
    input  logic                bit_in,
    output logic signed [W-1:0] sample_out
);

    localparam logic signed [W-1:0] POS_ONE = W'(1);
    localparam logic signed [W-1:0] NEG_ONE = '1;

    logic signed [W-1:0] integ_q [ORDER];
    logic signed [W-1:0] integ_d [ORDER];
    logic signed [W-1:0] dly_q   [ORDER];
    logic signed [W-1:0] dly_d   [ORDER];
    logic signed [W-1:0] acc;
    logic signed [W-1:0] diff;

    always_comb begin
        integ_d = integ_q;
        dly_d   = dly_q;
        acc     = bit_in ? POS_ONE : NEG_ONE;
        // Each integrator adds the freshly updated value of the stage before it.
        for (int k = 0; k < ORDER; k++) begin
            acc = integ_q[k] + acc;
            if (strobe) integ_d[k] = acc;
        end
        diff = integ_q[ORDER-1];
        for (int k = 0; k < ORDER; k++) begin
            if (dec_strobe) dly_d[k] = diff;
            diff = diff - dly_q[k];
        end
        sample_out = diff;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < ORDER; k++) begin
                integ_q[k] <= '0;
                dly_q[k]   <= '0;
            end
        end else begin
            integ_q <= integ_d;
            dly_q   <= dly_d;
        end
    end

endmodule

// File: rtl/pdm_cic_array.sv
// Multi-mic PDM front end: bit clock generation, L/R capture, per-channel CIC
// decimation and a valid/ready serializer that emits one channel per beat.
module pdm_cic_array
    import pdm_pkg::*;
#(
    parameter  int CLK_DIV  = 4,
    parameter  int NUM_MICS = 2,
    parameter  int DECIM    = 32,
    parameter  int ORDER    = 3,
    localparam int W        = cic_width(ORDER, DECIM),
    localparam int C        = SIDES * NUM_MICS,
    localparam int CW       = chan_idx_width(C)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic [NUM_MICS-1:0] pdm_data,
    output logic                pdm_clk,
    output logic                out_valid,
    input  logic                out_ready,
    output logic signed [W-1:0] out_data,
    output logic [CW-1:0]       out_chan,
    output logic                out_last,
    output logic                overrun
);

    localparam int DIV_W  = $clog2(CLK_DIV);
    localparam int DEC_W  = $clog2(DECIM);
    localparam int WARM_W = $clog2(ORDER + 1);
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [DEC_W-1:0]  DEC_LAST  = DEC_W'(DECIM - 1);
    localparam logic [WARM_W-1:0] WARM_DONE = WARM_W'(ORDER);
    localparam logic [CW-1:0]     CHAN_LAST = CW'(C - 1);

    logic                clr;
    logic                strobe;
    logic                left_cap;
    logic                accept;
    logic                last_beat;
    logic [C-1:0]        chan_bits;
    logic signed [W-1:0] samples [C];

    logic [DIV_W-1:0]    div_cnt_q, div_cnt_d;
    logic                phase_q, phase_d;
    logic [NUM_MICS-1:0] left_q, left_d;
    logic [DEC_W-1:0]    dec_cnt_q, dec_cnt_d;
    logic                dec_q, dec_d;
    logic [WARM_W-1:0]   warm_q, warm_d;
    logic                valid_q, valid_d;
    logic [CW-1:0]       chan_q, chan_d;
    logic                ovr_q, ovr_d;
    logic signed [W-1:0] frame_q [C];
    logic signed [W-1:0] frame_d [C];

    assign clr      = rst | ~en;
    assign strobe   = ~phase_q & (div_cnt_q == DIV_LAST);
    assign left_cap =  phase_q & (div_cnt_q == DIV_LAST);

    // Left bits come from the previous high phase; right bits are taken live on the strobe cycle.
    for (genvar m = 0; m < NUM_MICS; m++) begin : g_map
        assign chan_bits[chan_of(m, SIDE_LEFT)]  = left_q[m];
        assign chan_bits[chan_of(m, SIDE_RIGHT)] = pdm_data[m];
    end

    for (genvar ch = 0; ch < C; ch++) begin : g_chan
        pdm_cic_chan #(
            .DECIM (DECIM),
            .ORDER (ORDER)
        ) u_chan (
            .clk        (clk),
            .rst        (clr),
            .strobe     (strobe),
            .dec_strobe (dec_q),
            .bit_in     (chan_bits[ch]),
            .sample_out (samples[ch])
        );
    end

    always_comb begin
        div_cnt_d = div_cnt_q + 1'b1;
        phase_d   = phase_q;
        left_d    = left_q;
        dec_cnt_d = dec_cnt_q;
        dec_d     = 1'b0;
        warm_d    = warm_q;
        valid_d   = valid_q;
        chan_d    = chan_q;
        ovr_d     = ovr_q;
        frame_d   = frame_q;
        last_beat = valid_q & (chan_q == CHAN_LAST);
        accept    = valid_q & out_ready;

        if (div_cnt_q == DIV_LAST) begin
            div_cnt_d = '0;
            phase_d   = ~phase_q;
        end
        if (left_cap) left_d = pdm_data;
        if (strobe) begin
            dec_d     = (dec_cnt_q == DEC_LAST);
            dec_cnt_d = (dec_cnt_q == DEC_LAST) ? '0 : dec_cnt_q + 1'b1;
        end

        if (accept) begin
            if (last_beat) begin
                valid_d = 1'b0;
                chan_d  = '0;
            end else begin
                chan_d = chan_q + 1'b1;
            end
        end

        // A final beat accepted on the load cycle frees the buffer for the new frame.
        if (dec_q) begin
            if (warm_q != WARM_DONE) begin
                warm_d = warm_q + 1'b1;
            end else if (!valid_q || (accept && last_beat)) begin
                frame_d = samples;
                valid_d = 1'b1;
                chan_d  = '0;
            end else begin
                ovr_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            div_cnt_q <= '0;
            phase_q   <= 1'b0;
            left_q    <= '0;
            dec_cnt_q <= '0;
            dec_q     <= 1'b0;
            warm_q    <= '0;
            valid_q   <= 1'b0;
            chan_q    <= '0;
            ovr_q     <= 1'b0;
            for (int ch = 0; ch < C; ch++) frame_q[ch] <= '0;
        end else begin
            div_cnt_q <= div_cnt_d;
            phase_q   <= phase_d;
            left_q    <= left_d;
            dec_cnt_q <= dec_cnt_d;
            dec_q     <= dec_d;
            warm_q    <= warm_d;
            valid_q   <= valid_d;
            chan_q    <= chan_d;
            ovr_q     <= ovr_d;
            frame_q   <= frame_d;
        end
    end

    assign pdm_clk   = phase_q;
    assign out_valid = valid_q;
    assign out_chan  = chan_q;
    assign out_data  = frame_q[chan_q];
    assign out_last  = last_beat;
    assign overrun   = ovr_q;

endmodule

// File: tb/tb_pdm_cic_array.sv
// Randomized bench for pdm_cic_array: a convolution-based CIC reference model
// plus a frame-level output scoreboard.
module tb_pdm_cic_array;

    localparam int CLK_DIV  = 4;
    localparam int NUM_MICS = 1;
    localparam int DECIM    = 8;
    localparam int ORDER    = 2;
    localparam int W        = ORDER * $clog2(DECIM) + 1;
    localparam int C        = 2 * NUM_MICS;
    localparam int PER      = 2 * CLK_DIV;
    localparam int FCYC     = PER * DECIM;
    localparam int HLEN     = ORDER * (DECIM - 1) + 1;
    localparam int MAXS     = 256;
    localparam int MASK     = (1 << W) - 1;

    localparam int P_ONES = 0, P_LR = 1, P_ALT = 2, P_RAND = 3;
    localparam int R_ALL = 0, R_RAND = 1, R_STALL = 2, R_COINC = 3, R_ONE = 4;

    logic                clk = 1'b0;
    logic                rst;
    logic                en;
    logic [NUM_MICS-1:0] pdm_data;
    logic                pdm_clk;
    logic                out_valid;
    logic                out_ready;
    logic signed [W-1:0] out_data;
    logic [0:0]          out_chan;
    logic                out_last;
    logic                overrun;

    pdm_cic_array #(
        .CLK_DIV  (CLK_DIV),
        .NUM_MICS (NUM_MICS),
        .DECIM    (DECIM),
        .ORDER    (ORDER)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .pdm_data  (pdm_data),
        .pdm_clk   (pdm_clk),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_chan  (out_chan),
        .out_last  (out_last),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    int h [HLEN];
    int xl [MAXS];
    int xr [MAXS];
    bit lbit [MAXS];
    bit rbit [MAXS];

    int k;
    int pend;
    int mchan;
    bit ovr_exp;
    bit acc_prev;
    int exp_frame [C];
    int cur_pat;

    task automatic check(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s @k=%0d: got %0d, expected %0d", tag, k, obs, exp);
        end
    endtask

    function automatic longint uw(input logic [W-1:0] v);
        return longint'(v);
    endfunction

    // Impulse response of the CIC: boxcar of length DECIM convolved ORDER times.
    task automatic build_h();
        int tmp [HLEN];
        int len;
        for (int i = 0; i < HLEN; i++) h[i] = 0;
        h[0] = 1;
        len = 1;
        for (int o = 0; o < ORDER; o++) begin
            for (int i = 0; i < HLEN; i++) tmp[i] = 0;
            for (int i = 0; i < len; i++)
                for (int j = 0; j < DECIM; j++) tmp[i+j] += h[i];
            len += DECIM - 1;
            h = tmp;
        end
    endtask

    function automatic int model_sample(input int f, input int ch);
        int n;
        int acc;
        n = DECIM * f - 1;
        acc = 0;
        for (int t = 0; t < HLEN; t++)
            if (n - t >= 0) acc += h[t] * ((ch == 0) ? xl[n-t] : xr[n-t]);
        return acc & MASK;
    endfunction

    function automatic int lit_val(input int pat, input int ch);
        case (pat)
            P_ONES:  return 64 & MASK;
            P_LR:    return ((ch == 0) ? 64 : -64) & MASK;
            default: return 0;
        endcase
    endfunction

    // Left sample of strobe 0 is the cleared capture register (bit 0 -> -1).
    task automatic gen_bits(input int pat);
        cur_pat = pat;
        for (int s = 0; s < MAXS; s++) begin
            case (pat)
                P_ONES:  begin lbit[s] = 1'b1; rbit[s] = 1'b1; end
                P_LR:    begin lbit[s] = 1'b1; rbit[s] = 1'b0; end
                P_ALT:   begin lbit[s] = (s % 2 == 0); rbit[s] = (s % 2 == 0); end
                default: begin lbit[s] = 1'($urandom % 2); rbit[s] = 1'($urandom % 2); end
            endcase
            xl[s] = (s == 0) ? -1 : (lbit[s] ? 1 : -1);
            xr[s] = rbit[s] ? 1 : -1;
        end
    endtask

    task automatic model_restart();
        k = 0; pend = 0; mchan = 0; ovr_exp = 1'b0; acc_prev = 1'b0;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_pdm_clk"}, pdm_clk, 0);
        check({tag, "_valid"}, out_valid, 0);
        check({tag, "_overrun"}, overrun, 0);
        check({tag, "_data"}, uw(out_data), 0);
        check({tag, "_chan"}, out_chan, 0);
        check({tag, "_last"}, out_last, 0);
    endtask

    task automatic do_reset();
        rst = 1'b1; out_ready = 1'b0; pdm_data = '0;
        @(negedge clk);
        check_idle("rst");
        rst = 1'b0;
        model_restart();
    endtask

    task automatic en_low();
        en = 1'b0; out_ready = 1'b1;
        repeat (10) begin
            @(negedge clk);
            check_idle("en_low");
        end
        en = 1'b1;
        model_restart();
    endtask

    task automatic run_cycles(input int n, input int rmode);
        bit r;
        bit pd;
        int f;
        for (int i = 0; i < n; i++) begin
            if (acc_prev) begin pend--; mchan++; end
            if ((k + 3) % FCYC == 0) begin
                f = (k + 3) / FCYC;
                if (f > ORDER) begin
                    if (pend == 0) begin
                        for (int ch = 0; ch < C; ch++) exp_frame[ch] = model_sample(f, ch);
                        pend = C; mchan = 0;
                    end else begin
                        ovr_exp = 1'b1;
                    end
                end
            end
            check("pdm_clk", pdm_clk, (k / CLK_DIV) % 2);
            check("valid", out_valid, pend > 0);
            check("overrun", overrun, ovr_exp);
            if (pend > 0) begin
                check("chan", out_chan, mchan);
                check("data", uw(out_data), exp_frame[mchan]);
                check("last", out_last, mchan == C - 1);
                if (cur_pat != P_RAND) check("lit_data", uw(out_data), lit_val(cur_pat, mchan));
            end else begin
                check("last_idle", out_last, 0);
            end
            case (rmode)
                R_ALL:   r = 1'b1;
                R_RAND:  r = ($urandom_range(0, 3) != 0);
                R_STALL: r = !(k >= 180 && k < 330);
                R_COINC: r = (k % FCYC == FCYC - 5) || (k % FCYC == FCYC - 4);
                default: r = (k % FCYC == FCYC - 3);
            endcase
            out_ready = r;
            pd = 1'($urandom % 2);
            if (k % PER == CLK_DIV - 1) pd = rbit[k / PER];
            else if (k % PER == PER - 1) pd = lbit[k / PER + 1];
            pdm_data = pd;
            acc_prev = (pend > 0) && r;
            @(negedge clk);
            k++;
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; out_ready = 1'b0; pdm_data = '0;
        cur_pat = P_ONES;
        model_restart();
        build_h();
        @(negedge clk);

        do_reset(); gen_bits(P_ONES); run_cycles(350, R_ALL);
        do_reset(); gen_bits(P_LR);   run_cycles(350, R_ALL);
        do_reset(); gen_bits(P_ALT);  run_cycles(350, R_ALL);
        do_reset(); gen_bits(P_RAND); run_cycles(700, R_RAND);

        do_reset(); gen_bits(P_RAND); run_cycles(450, R_STALL);
        check("ovr_sticky", overrun, 1);
        en_low(); gen_bits(P_RAND); run_cycles(300, R_ALL);

        do_reset(); gen_bits(P_RAND); run_cycles(500, R_COINC);

        do_reset(); gen_bits(P_RAND); run_cycles(3 * FCYC - 1, R_ONE);
        do_reset(); gen_bits(P_RAND); run_cycles(300, R_ALL);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
